// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and opcode constants for the execution dispatcher
package core_pkg;

  typedef enum logic [1:0] {
    RST_HOLD,
    IDLE,
    EXEC
  } dispatch_state_t;

  localparam logic [2:0] OPC_ALU  = 3'b100;
  localparam logic [2:0] OPC_PFCU = 3'b110;
  localparam logic [2:0] OPC_MIO  = 3'b010;

endpackage

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - holds unit resets for RST_HOLD cycles after rst falls
module reset_sequencer #(
  parameter int RST_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  output logic hold_done
);

  localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(RST_HOLD - 1);

  logic [CW-1:0] cnt;
  logic          holding;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      holding <= 1'b1;
    end else if (holding) begin
      if (cnt == LAST) holding <= 1'b0;
      else             cnt     <= cnt + 1'b1;
    end
  end

  // High in the last hold cycle; the dispatcher leaves RST_HOLD on this edge.
  assign hold_done = holding && (cnt == LAST);

endmodule

// File: rtl/exec_dispatch_unit.sv
// rtl/exec_dispatch_unit.sv - dispatches queued instructions to one of N execution units
module exec_dispatch_unit #(
  parameter int                          N_UNITS     = 3,
  parameter int                          INST_W      = 32,
  parameter int                          OPC_W       = 3,
  parameter logic [N_UNITS*OPC_W-1:0]    UNIT_OPC    = {3'b010, 3'b110, 3'b100},
  parameter int                          NUM_GPR     = 16,
  parameter int                          DATA_W      = 32,
  parameter int                          RST_HOLD    = 4,
  parameter int                          TIMEOUT_CYC = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 inst_valid,
  input  logic [INST_W-1:0]                    inst,
  output logic                                 inst_ready,
  output logic [INST_W-1:0]                    cur_inst,
  output logic [N_UNITS-1:0]                   unit_en,
  input  logic [N_UNITS-1:0]                   unit_done,
  output logic [N_UNITS-1:0]                   unit_rst,
  input  logic [N_UNITS-1:0]                   unit_wr_en,
  input  logic [N_UNITS*$clog2(NUM_GPR)-1:0]   unit_wr_idx,
  input  logic [N_UNITS*DATA_W-1:0]            unit_wr_data,
  output logic [NUM_GPR-1:0]                   gpr_we,
  output logic [DATA_W-1:0]                    gpr_wdata,
  output logic                                 busy,
  output logic                                 illegal_trap,
  output logic                                 timeout_trap
);

  import core_pkg::*;

  localparam int IDX_W = $clog2(NUM_GPR);
  localparam int AW    = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit WD_ON = (TIMEOUT_CYC > 0);
  localparam logic [WD_W-1:0]    WD_LAST  = WD_ON ? WD_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [N_UNITS-1:0] UNIT_ONE = 1;
  localparam logic [NUM_GPR-1:0] GPR_ONE  = 1;

  dispatch_state_t  state;
  logic [AW-1:0]    act;
  logic [WD_W-1:0]  wd_cnt;

  logic             hold_done;
  logic             match_any;
  logic [AW-1:0]    match_idx;
  logic [OPC_W-1:0] opc;

  logic              done_act;
  logic              wr_en_act;
  logic [IDX_W-1:0]  wr_idx_act;
  logic [DATA_W-1:0] wr_data_act;
  logic              wd_expire;

  reset_sequencer #(
    .RST_HOLD (RST_HOLD)
  ) u_reset_sequencer (
    .clk       (clk),
    .rst       (rst),
    .hold_done (hold_done)
  );

  assign opc = inst[OPC_W-1:0];

  // Scan from the top so the lowest matching unit is the one left standing.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int k = N_UNITS - 1; k >= 0; k--) begin
      if (opc == UNIT_OPC[k*OPC_W +: OPC_W]) begin
        match_any = 1'b1;
        match_idx = AW'(k);
      end
    end
  end

  assign done_act    = unit_done[act];
  assign wr_en_act   = unit_wr_en[act];
  assign wr_idx_act  = unit_wr_idx[int'(act)*IDX_W +: IDX_W];
  assign wr_data_act = unit_wr_data[int'(act)*DATA_W +: DATA_W];
  assign wd_expire   = WD_ON && (wd_cnt == WD_LAST);

  assign illegal_trap = (state == IDLE) && inst_valid && !match_any;
  assign timeout_trap = (state == EXEC) && !done_act && wd_expire;
  assign inst_ready   = illegal_trap || ((state == EXEC) && (done_act || wd_expire));
  assign busy         = (state != IDLE) && !rst;

  always_comb begin
    gpr_we    = '0;
    gpr_wdata = '0;
    if ((state == EXEC) && wr_en_act) begin
      gpr_we    = GPR_ONE << wr_idx_act;
      gpr_wdata = wr_data_act;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= core_pkg::RST_HOLD;
      unit_rst <= '1;
      unit_en  <= '0;
      cur_inst <= '0;
      act      <= '0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        core_pkg::RST_HOLD: begin
          if (hold_done) begin
            unit_rst <= '0;
            state    <= IDLE;
          end
        end
        IDLE: begin
          // Clears the one-cycle unit reset left behind by a watchdog expiry.
          unit_rst <= '0;
          if (inst_valid && match_any) begin
            cur_inst <= inst;
            act      <= match_idx;
            unit_en  <= UNIT_ONE << match_idx;
            wd_cnt   <= '0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (done_act) begin
            unit_en <= '0;
            state   <= IDLE;
          end else if (wd_expire) begin
            unit_en  <= '0;
            unit_rst <= UNIT_ONE << act;
            state    <= IDLE;
          end else if (WD_ON) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          unit_en <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_dispatch_unit.sv
// tb/tb_exec_dispatch_unit.sv - directed self-checking bench for exec_dispatch_unit
module tb_exec_dispatch_unit;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [31:0] cur_inst;
  logic [2:0]  unit_en;
  logic [2:0]  unit_done;
  logic [2:0]  unit_rst;
  logic [2:0]  unit_wr_en;
  logic [11:0] unit_wr_idx;
  logic [95:0] unit_wr_data;
  logic [15:0] gpr_we;
  logic [31:0] gpr_wdata;
  logic        busy;
  logic        illegal_trap;
  logic        timeout_trap;

  int n_checks = 0;
  int n_errors = 0;

  exec_dispatch_unit #(
    .RST_HOLD    (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_ready   (inst_ready),
    .cur_inst     (cur_inst),
    .unit_en      (unit_en),
    .unit_done    (unit_done),
    .unit_rst     (unit_rst),
    .unit_wr_en   (unit_wr_en),
    .unit_wr_idx  (unit_wr_idx),
    .unit_wr_data (unit_wr_data),
    .gpr_we       (gpr_we),
    .gpr_wdata    (gpr_wdata),
    .busy         (busy),
    .illegal_trap (illegal_trap),
    .timeout_trap (timeout_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    inst_valid   = 1'b0;
    inst         = '0;
    unit_done    = '0;
    unit_wr_en   = '0;
    unit_wr_idx  = '0;
    unit_wr_data = '0;
    tick();
    tick();

    // reset state
    chk("rst_unit_rst", unit_rst, 3'b111);
    chk("rst_unit_en", unit_en, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_inst_ready", inst_ready, 1'b0);
    chk("rst_cur_inst", cur_inst, 32'h0);
    chk("rst_gpr_we", gpr_we, 16'h0);

    // reset hold: four cycles after rst falls
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("hold_unit_rst_%0d", i), unit_rst, (i < 4) ? 3'b111 : 3'b000);
      chk($sformatf("hold_busy_%0d", i), busy, (i < 4) ? 1'b1 : 1'b0);
    end

    // ALU dispatch, completion after 5 EXEC cycles
    inst = 32'h0000_0004;
    inst_valid = 1'b1;
    #1;
    chk("alu_no_pop_on_accept", inst_ready, 1'b0);
    tick();
    inst_valid = 1'b0;
    chk("alu_unit_en", unit_en, 3'b001);
    chk("alu_busy", busy, 1'b1);
    chk("alu_cur_inst", cur_inst, 32'h0000_0004);
    unit_done = 3'b010;
    #1;
    chk("alu_foreign_done_ignored", inst_ready, 1'b0);
    tick();
    unit_done = 3'b000;
    chk("alu_en_held", unit_en, 3'b001);
    tick();
    tick();
    tick();
    unit_done = 3'b001;
    #1;
    chk("alu_done_pop", inst_ready, 1'b1);
    chk("alu_done_no_trap", timeout_trap, 1'b0);
    tick();
    unit_done = 3'b000;
    chk("alu_en_cleared", unit_en, 3'b000);
    chk("alu_idle", busy, 1'b0);

    // illegal opcode
    inst = 32'h0000_0007;
    inst_valid = 1'b1;
    #1;
    chk("ill_trap", illegal_trap, 1'b1);
    chk("ill_pop", inst_ready, 1'b1);
    tick();
    inst_valid = 1'b0;
    #1;
    chk("ill_unit_en", unit_en, 3'b000);
    chk("ill_trap_cleared", illegal_trap, 1'b0);
    chk("ill_busy", busy, 1'b0);

    // GPR mux: ALU writes, MIOU write must not leak
    inst = 32'h0000_0004;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    unit_wr_en   = 3'b101;
    unit_wr_idx  = {4'd9, 4'd0, 4'd5};
    unit_wr_data = {32'h1234_5678, 32'h0, 32'hDEAD_BEEF};
    #1;
    chk("gpr_we_alu", gpr_we, 16'h0020);
    chk("gpr_wdata_alu", gpr_wdata, 32'hDEAD_BEEF);
    unit_wr_en = 3'b100;
    #1;
    chk("gpr_we_miou_only", gpr_we, 16'h0000);
    chk("gpr_wdata_miou_only", gpr_wdata, 32'h0);
    unit_wr_en = 3'b000;
    unit_done = 3'b001;
    tick();
    unit_done = 3'b000;
    unit_wr_en = 3'b001;
    #1;
    chk("gpr_we_idle", gpr_we, 16'h0000);
    unit_wr_en = 3'b000;

    // watchdog: PFCU never completes
    inst = 32'h0000_0006;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("wd_unit_en", unit_en, 3'b010);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("wd_no_trap_c%0d", c), timeout_trap, 1'b0);
      tick();
    end
    chk("wd_trap", timeout_trap, 1'b1);
    chk("wd_pop", inst_ready, 1'b1);
    tick();
    chk("wd_unit_rst", unit_rst, 3'b010);
    chk("wd_unit_en_off", unit_en, 3'b000);
    chk("wd_idle", busy, 1'b0);
    tick();
    chk("wd_unit_rst_cleared", unit_rst, 3'b000);

    // done on the expiry cycle wins (MIOU)
    inst = 32'h0000_0002;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("race_unit_en", unit_en, 3'b100);
    for (int c = 1; c <= 7; c++) tick();
    unit_done = 3'b100;
    #1;
    chk("race_no_trap", timeout_trap, 1'b0);
    chk("race_pop", inst_ready, 1'b1);
    tick();
    unit_done = 3'b000;
    chk("race_no_unit_rst", unit_rst, 3'b000);
    chk("race_unit_en_off", unit_en, 3'b000);

    // asynchronous reset in EXEC cycle 3
    inst = 32'h0000_0004;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    tick();
    chk("arst_pre_en", unit_en, 3'b001);
    #1;
    rst = 1'b1;
    unit_done = 3'b001;
    #1;
    chk("arst_unit_en", unit_en, 3'b000);
    chk("arst_unit_rst", unit_rst, 3'b111);
    chk("arst_no_pop", inst_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    unit_done = 3'b000;
    tick();
    tick();
    tick();
    chk("arst_hold_3", unit_rst, 3'b111);
    tick();
    chk("arst_release", unit_rst, 3'b000);
    chk("arst_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
